// File: rtl/bcd_timer_pkg.sv
// Shared constants and helpers for the BCD timer: seven-segment table,
// per-digit modulus and the BCD digit type.
package bcd_timer_pkg;

  typedef logic [3:0] bcd_t;

  // Active-high segment patterns, bit 0 = a ... bit 6 = g
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  // Even digits count 0..9, odd digits 0..5 (ss, mm:ss, ...)
  function automatic int digit_mod(input int i);
    return (i % 2 == 0) ? 10 : 6;
  endfunction

  // Digits never exceed 9, so the blank default is only for completeness
  function automatic logic [6:0] seg_decode(input bcd_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return 7'b0000000;
    endcase
  endfunction

endpackage

// File: rtl/bcd_timer_digit.sv
// One BCD digit of modulus MOD: increments/decrements when enabled, loads a
// clamped preset, and reports carry/borrow out when it is at its terminal value.
module bcd_digit
  import bcd_timer_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic up_i,
  input  logic load_i,
  input  bcd_t d_i,
  output bcd_t q_o,
  output logic cy_o
);

  localparam bcd_t QMAX = bcd_t'(MOD - 1);

  bcd_t q_q, q_d;
  logic term;

  // Terminal value depends on direction: max when counting up, 0 when down
  assign term = up_i ? (q_q == QMAX) : (q_q == 4'd0);
  assign cy_o = en_i & term;
  assign q_o  = q_q;

  // Next digit value: load (clamped) beats a count step
  always_comb begin
    q_d = q_q;
    if (load_i)
      q_d = (d_i > QMAX) ? QMAX : d_i;
    else if (en_i) begin
      if (up_i) q_d = term ? 4'd0 : q_q + 4'd1;
      else      q_d = term ? QMAX : q_q - 4'd1;
    end
  end

  // Digit register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

endmodule

// File: rtl/bcd_timer.sv
// Parametrised BCD timer/counter: prescaler, chain of bcd_digit instances
// enabled by carry, registered tick/wrap pulses and a zero flag.
// Define BCD_TIMER_SEG_EN to generate the seg port and per-digit decoders.
module bcd_timer
  import bcd_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50_000_000,
  parameter int DOWN_STOP  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] preset,
  output logic [4*NUM_DIGITS-1:0] bcd,
`ifdef BCD_TIMER_SEG_EN
  output logic [7*NUM_DIGITS-1:0] seg,
`endif
  output logic                    tick,
  output logic                    wrap,
  output logic                    zero
);

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic                  tick_q, wrap_q;
  logic [NUM_DIGITS-1:0] en, cy;
  logic                  at_end, step, hold;

  assign at_end = (presc_q == PMAX);
  // A load on the step edge swallows the step
  assign step   = run & at_end & ~load;
  // Down-stop: freeze at all-zero, but the tick still fires
  assign hold   = (DOWN_STOP != 0) & ~up & zero;
  assign en[0]  = step & ~hold;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      if (g > 0) begin : g_chain
        assign en[g] = cy[g-1];
      end
      bcd_digit #(.MOD(digit_mod(g))) u_dig (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (en[g]),
        .up_i   (up),
        .load_i (load),
        .d_i    (preset[4*g +: 4]),
        .q_o    (bcd[4*g +: 4]),
        .cy_o   (cy[g])
      );
`ifdef BCD_TIMER_SEG_EN
      assign seg[7*g +: 7] = seg_decode(bcd[4*g +: 4]);
`endif
    end
  endgenerate

  assign zero = (bcd == '0);
  assign tick = tick_q;
  assign wrap = wrap_q;

  // Prescaler next state: cleared by load, frozen while paused
  always_comb begin
    presc_d = presc_q;
    if (load)
      presc_d = '0;
    else if (run)
      presc_d = at_end ? '0 : presc_q + 1'b1;
  end

  // Prescaler and pulse registers; wrap means the carry left the top digit
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= step;
      wrap_q  <= step & cy[NUM_DIGITS-1];
    end
  end

endmodule

// File: tb/tb_bcd_timer.sv
// Bench for bcd_timer: two instances (wrapping and down-stop) share stimulus
// and are compared each cycle against an integer-valued reference model.
module tb_bcd_timer;

  localparam int ND = 4;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          reset, run, up, load;
  logic [4*ND-1:0] preset;
  logic [4*ND-1:0] bcd_a, bcd_b;
  logic          tick_a, wrap_a, zero_a, tick_b, wrap_b, zero_b;
`ifdef BCD_TIMER_SEG_EN
  logic [7*ND-1:0] seg_a, seg_b;
`endif

  always #5 clk = ~clk;

  bcd_timer #(.NUM_DIGITS(ND), .TICK_DIV(TD), .DOWN_STOP(0)) u_dut_a (
    .clk(clk), .reset(reset), .run(run), .up(up), .load(load), .preset(preset),
    .bcd(bcd_a),
`ifdef BCD_TIMER_SEG_EN
    .seg(seg_a),
`endif
    .tick(tick_a), .wrap(wrap_a), .zero(zero_a));

  bcd_timer #(.NUM_DIGITS(ND), .TICK_DIV(TD), .DOWN_STOP(1)) u_dut_b (
    .clk(clk), .reset(reset), .run(run), .up(up), .load(load), .preset(preset),
    .bcd(bcd_b),
`ifdef BCD_TIMER_SEG_EN
    .seg(seg_b),
`endif
    .tick(tick_b), .wrap(wrap_b), .zero(zero_b));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: count held as a plain integer in 0..MTOT-1
  int va = 0, vb = 0, p = 0;
  bit mt = 0, mwa = 0, mwb = 0;

  function automatic int dmod(input int i);
    return (i % 2 == 0) ? 10 : 6;
  endfunction

  function automatic int mtot();
    int m = 1;
    for (int i = 0; i < ND; i++) m *= dmod(i);
    return m;
  endfunction

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r = '0;
    int x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % dmod(i));
      x = x / dmod(i);
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [4*ND-1:0] pre);
    int v = 0, w = 1, d;
    for (int i = 0; i < ND; i++) begin
      d = int'(pre[4*i +: 4]);
      if (d >= dmod(i)) d = dmod(i) - 1;
      v += d * w;
      w *= dmod(i);
    end
    return v;
  endfunction

  task automatic model_step(inout int v, output bit w, input bit stop);
    w = 0;
    if (up) begin
      w = (v == mtot() - 1);
      v = (v + 1) % mtot();
    end else if (v == 0) begin
      if (!stop) begin v = mtot() - 1; w = 1; end
    end else
      v = v - 1;
  endtask

  task automatic model_edge();
    mt = 0; mwa = 0; mwb = 0;
    if (!reset) begin
      va = 0; vb = 0; p = 0;
    end else if (load) begin
      va = clamp_val(preset); vb = va; p = 0;
    end else if (run) begin
      if (p == TD - 1) begin
        p = 0; mt = 1;
        model_step(va, mwa, 1'b0);
        model_step(vb, mwb, 1'b1);
      end else
        p++;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check_all();
    chk("bcd_a", 64'(bcd_a), 64'(to_bcd(va)));
    chk("tick_a", 64'(tick_a), 64'(mt));
    chk("wrap_a", 64'(wrap_a), 64'(mwa));
    chk("zero_a", 64'(zero_a), 64'(va == 0));
    chk("bcd_b", 64'(bcd_b), 64'(to_bcd(vb)));
    chk("tick_b", 64'(tick_b), 64'(mt));
    chk("wrap_b", 64'(wrap_b), 64'(mwb));
    chk("zero_b", 64'(zero_b), 64'(vb == 0));
`ifdef BCD_TIMER_SEG_EN
    begin
      logic [7*ND-1:0] es;
      logic [4*ND-1:0] eb;
      eb = to_bcd(va);
      for (int i = 0; i < ND; i++) es[7*i +: 7] = segtab[eb[4*i +: 4]];
      chk("seg_a", 64'(seg_a), 64'(es));
    end
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; up = 1'b1; load = 1'b0; preset = '0;

    // Reset
    cycle();
    chk("rst_bcd", 64'(bcd_a), 64'h0);
    chk("rst_zero", 64'(zero_a), 64'h1);
    chk("rst_tick", 64'(tick_a), 64'h0);
`ifdef BCD_TIMER_SEG_EN
    chk("rst_seg0", 64'(seg_a[6:0]), 64'h3F);
`endif

    // Up count: 10 ticks then 60 ticks
    reset = 1'b1; run = 1'b1; up = 1'b1;
    repeat (10 * TD) cycle();
    chk("up10", 64'(bcd_a), 64'h0010);
    repeat (50 * TD) cycle();
    chk("up60", 64'(bcd_a), 64'h0100);

    // Up wrap from 59:59
    load = 1'b1; preset = 16'h5959;
    cycle();
    load = 1'b0;
    chk("ld5959", 64'(bcd_a), 64'h5959);
    repeat (TD) cycle();
    chk("upwrap_bcd", 64'(bcd_a), 64'h0000);
    chk("upwrap_w", 64'(wrap_a), 64'h1);
    cycle();
    chk("upwrap_1cyc", 64'(wrap_a), 64'h0);

    // Down from zero: wrap vs stop
    reset = 1'b0; cycle();
    reset = 1'b1; up = 1'b0;
    repeat (TD) cycle();
    chk("dn_bcd_a", 64'(bcd_a), 64'h5959);
    chk("dn_wrap_a", 64'(wrap_a), 64'h1);
    chk("dn_bcd_b", 64'(bcd_b), 64'h0000);
    chk("dn_tick_b", 64'(tick_b), 64'h1);
    chk("dn_wrap_b", 64'(wrap_b), 64'h0);

    // Clamp
    load = 1'b1; preset = 16'h0A7F;
    cycle();
    load = 1'b0;
    chk("clamp", 64'(bcd_a), 64'h0959);

    // Pause at prescaler=2
    reset = 1'b0; cycle();
    reset = 1'b1; up = 1'b1; run = 1'b1;
    repeat (2) cycle();
    run = 1'b0;
    repeat (10) cycle();
    chk("pause_bcd", 64'(bcd_a), 64'h0000);
    run = 1'b1;
    cycle();
    chk("resume1", 64'(tick_a), 64'h0);
    cycle();
    chk("resume2", 64'(tick_a), 64'h1);
    chk("resume2_bcd", 64'(bcd_a), 64'h0001);

    // Reset beats load
    run = 1'b0; load = 1'b1; preset = 16'h1234;
    cycle();
    reset = 1'b0; preset = 16'h5959;
    cycle();
    chk("rst_over_ld", 64'(bcd_a), 64'h0000);
    reset = 1'b1; load = 1'b0;

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      run    = ($urandom_range(0, 9) != 0);
      up     = ($urandom_range(0, 63) == 0) ? ~up : up;
      load   = ($urandom_range(0, 39) == 0);
      reset  = ($urandom_range(0, 199) != 0);
      preset = 16'($urandom);
      if ($urandom_range(0, 3) == 0) preset = 16'h0000;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_timer.md
# bcd_timer

Parametrised single-clock BCD timer and counter for the lab FPGA boards, and the successor to the two-digit 0–59 seconds counter. It generalises that counter to NUM_DIGITS digits with alternating mod-10/mod-6 digits (ss, mm:ss, …), and adds up/down counting, run/pause, synchronous preset load and terminal pulses. All digits advance on one clock via enables, with no ripple or derived clocks. It sits between the board clock/reset and the seven-segment displays.

## Interface
Parameters:
- NUM_DIGITS, 4: number of BCD digits; range 1..8. Digit i has modulus 10 when i is even and 6 when i is odd.
- TICK_DIV, 50_000_000: clk cycles per count step; must be ≥1.
- DOWN_STOP, 0: when 1, down-counting halts at all-zero instead of wrapping.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset; reset=0 at a rising edge resets the block.
- run  in  1  1 = prescaler advances and counting proceeds; 0 = pause.
- up  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous preset load.
- preset  in  4*NUM_DIGITS  BCD preset; digit i occupies bits [4i+3:4i].
- bcd  out  4*NUM_DIGITS  current count, same packing as preset.
- seg  out  7*NUM_DIGITS  seven-segment patterns, active-high; bit 7i+0..6 = segments a..g of digit i. Present only with the configuration macro defined.
- tick  out  1  one-cycle pulse on each step edge.
- wrap  out  1  one-cycle pulse when the whole counter rolls over.
- zero  out  1  level; 1 when all digits are 0.

## Operation
- Reset (reset=0) forces the following: bcd=0, prescaler=0, tick=0, wrap=0. Consequently zero=1 and each seg digit shows "0" (7'b0111111). Reset overrides load and run.
- Priority at each edge: reset, then load, then step.
- Load: bcd←preset and prescaler←0, with no tick or wrap. Any preset digit ≥ its modulus is clamped to modulus−1.
- Prescaler counts 0..TICK_DIV−1 only while run=1. While run=0 it holds its value, so pause preserves phase.
- Step occurs at the edge where run=1 and prescaler=TICK_DIV−1. At that edge:
  - prescaler←0 and tick←1.
  - Up: digit 0 increments. Each digit at modulus−1 rolls to 0 and carries into the next digit.
  - Down: digit 0 decrements. Each digit at 0 rolls to modulus−1 and borrows from the next digit.
- wrap←1 on a step that moves all digits together:
  - up: from the all-max value to all-zero;
  - down: from all-zero to the all-max value.
- DOWN_STOP=1 with up=0 and bcd all-zero: the step leaves bcd unchanged. tick still pulses; wrap stays 0.
- A change on up is sampled at the step edge. It has no effect on the prescaler.

## Timing
- tick, wrap and the new bcd value all become visible in the cycle after the step edge. Every output is registered, and there is no combinational path from inputs to bcd, tick or wrap.
- zero and seg are combinational decodes of the bcd register, so they have zero additional latency.
- The tick period is exactly TICK_DIV cycles of run=1. With TICK_DIV=1, a step occurs on every cycle while run=1.
- A load at the step edge suppresses that step. The next step then follows TICK_DIV run-cycles later.

## Configuration
- BCD_TIMER_SEG_EN defined: the seg port and one decoder per digit are generated. Digit codes 0–9 map to standard patterns; the decoder never receives codes above 9.
- BCD_TIMER_SEG_EN undefined: there is no seg port and no decoder logic. All other behaviour is identical.

## Structure
- bcd_timer_pkg contains:
  - the seven-segment constant table SEG_0..SEG_9;
  - function digit_mod(i), which returns 10 or 6;
  - typedef bcd_t (logic [3:0]).
- Sub-module bcd_digit is instantiated once per digit. Its contents:
  - parameter MOD;
  - inputs en, up, load, d;
  - outputs q and cy, where cy = en and (q at its terminal value for the current direction);
  - the chain en[i+1] = cy[i].

## Test plan
Unless a line says otherwise: NUM_DIGITS=4, TICK_DIV=4, DOWN_STOP=0.
- Reset: hold reset=0 for 1 cycle → bcd=16'h0000, zero=1, tick=0, seg[6:0]=7'b0111111.
- Up count: run=1, up=1 → tick every 4 cycles; bcd=16'h0010 after 10 ticks and 16'h0100 after 60 ticks.
- Up wrap: load preset 16'h5959, then run up → at the next tick bcd=16'h0000 with wrap=1 for exactly one cycle.
- Down count from 16'h0000:
  - DOWN_STOP=0 → next tick gives bcd=16'h5959 with wrap=1;
  - DOWN_STOP=1 → bcd stays 16'h0000, tick=1, wrap=0.
- Clamp: load preset 16'h0A7F → bcd=16'h0959.
- Pause and reset:
  - run=0 for 10 cycles at prescaler=2 → bcd and phase are unchanged, and the step lands 2 run-cycles after resume;
  - reset=0 together with load=1 → bcd=16'h0000.
